// File: rtl/div_nonrestoring_pkg.sv
// div_nonrestoring_pkg: shared state encoding and sizing for the non-restoring divider
package div_nonrestoring_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  function automatic int cnt_width(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
  localparam int CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/div_nonrestoring_if.sv
// div_nonrestoring_if: request/result bundle between the EX stage and the divider
interface div_nonrestoring_if
  import div_nonrestoring_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/nonrestoring_step.sv
// nonrestoring_step: one shift-and-add/subtract iteration using an XOR mask with carry-in = sel
module nonrestoring_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   r,
  input  logic             q_bit,
  input  logic [WIDTH-1:0] d,
  input  logic             sel,
  output logic [WIDTH:0]   r_next,
  output logic             q_out
);
  assign r_next = {r[WIDTH-1:0], q_bit} + ({1'b0, d} ^ {(WIDTH+1){sel}}) + {{WIDTH{1'b0}}, sel};
  assign q_out = ~r_next[WIDTH];
endmodule

// File: rtl/div_nonrestoring.sv
// div_nonrestoring: multi-cycle unsigned non-restoring divider with divide-by-zero flag
module div_nonrestoring
  import div_nonrestoring_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic rst,
  div_nonrestoring_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_n;
  logic [WIDTH:0] r, r_step;
  logic [WIDTH-1:0] q, d;
  logic [CW-1:0] cnt;
  logic q_bit, accept, zero_div;
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign zero_div = bus.divisor == '0;
  // subtract while the partial remainder is non-negative
  nonrestoring_step #(.WIDTH(WIDTH)) u_step (
    .r(r), .q_bit(q[WIDTH-1]), .d(d), .sel(~r[WIDTH]), .r_next(r_step), .q_out(q_bit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !zero_div) begin
        r <= '0;
        q <= bus.dividend;
        d <= bus.divisor;
        cnt <= CW'(WIDTH - 1);
      end
      if (accept && zero_div) begin
        bus.quotient <= '1;
        bus.remainder <= bus.dividend;
        bus.div_by_zero <= 1'b1;
      end
      if (state == RUN) begin
        r <= r_step;
        q <= {q[WIDTH-2:0], q_bit};
        cnt <= cnt - CW'(1);
      end
      // the final correction only needs the low WIDTH bits of R + D
      if (state == FIX) begin
        bus.quotient <= q;
        bus.remainder <= r[WIDTH] ? r[WIDTH-1:0] + d : r[WIDTH-1:0];
        bus.div_by_zero <= 1'b0;
      end
    end
  end
  always_comb begin
    state_n = accept ? (zero_div ? DONE : RUN) :
              state == RUN ? (cnt == '0 ? FIX : RUN) :
              state == FIX ? DONE : IDLE;
  end
  always_comb begin
    bus.busy = state == RUN || state == FIX;
    bus.done = state == DONE;
  end
endmodule

// File: tb/tb_div_nonrestoring.sv
// tb_div_nonrestoring: vector table, timing corner cases and random ops against a/b, a%b
module tb_div_nonrestoring;
  import div_nonrestoring_pkg::*;
  localparam int W = DEF_WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div_nonrestoring_if #(.WIDTH(W)) bus();
  div_nonrestoring #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [W-1:0] rq, rr;
  logic rz;
  int lat;
  logic stable_ok, busy_ok;
  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic z;
  } vec_t;
  vec_t vt[10];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] pq, pr;
    logic pz;
    pq = bus.quotient;
    pr = bus.remainder;
    pz = bus.div_by_zero;
    stable_ok = 1'b1;
    busy_ok = 1'b1;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    tick;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.quotient !== pq || bus.remainder !== pr || bus.div_by_zero !== pz) stable_ok = 1'b0;
      tick;
      lat++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    rq = bus.quotient;
    rr = bus.remainder;
    rz = bus.div_by_zero;
  endtask
  initial begin
    int c;
    logic seen_done;
    logic [W-1:0] a, b;
    vt[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
    vt[3] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
    vt[4] = '{32'd7, 32'd9, 32'd0, 32'd7, 1'b0};
    vt[5] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    vt[6] = '{32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0};
    vt[7] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0};
    vt[8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 1'b0};
    vt[9] = '{32'd12345, 32'd100, 32'd123, 32'd45, 1'b0};
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tick;
    tick;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset quotient", 64'(bus.quotient), 64'd0);
    check("reset remainder", 64'(bus.remainder), 64'd0);
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b);
      check("vec latency", 64'(lat), vt[i].z ? 64'd1 : 64'(W + 2));
      check("vec quotient", 64'(rq), 64'(vt[i].q));
      check("vec remainder", 64'(rr), 64'(vt[i].r));
      check("vec div_by_zero", 64'(rz), 64'(vt[i].z));
      check("vec outputs stable while running", 64'(stable_ok), 64'd1);
      check("vec busy window", 64'(busy_ok), 64'd1);
      tick;
      check("vec done single pulse", 64'(bus.done), 64'd0);
      check("vec quotient held", 64'(bus.quotient), 64'(vt[i].q));
    end
    bus.start = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd33;
    tick;
    c = 1;
    while (!bus.done && c < 100) begin
      bus.start = c == 10;
      bus.dividend = 32'd9;
      bus.divisor = 32'd3;
      tick;
      c++;
    end
    bus.start = 1'b0;
    check("ignored start latency", 64'(c), 64'(W + 2));
    check("ignored start quotient", 64'(bus.quotient), 64'd30);
    check("ignored start remainder", 64'(bus.remainder), 64'd10);
    run_op(32'd9, 32'd3);
    check("back-to-back latency", 64'(lat), 64'(W + 2));
    check("back-to-back busy", 64'(busy_ok), 64'd1);
    check("back-to-back quotient", 64'(rq), 64'd3);
    check("back-to-back remainder", 64'(rr), 64'd0);
    bus.start = 1'b1;
    bus.dividend = 32'd12345;
    bus.divisor = 32'd100;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort quotient", 64'(bus.quotient), 64'd0);
    check("abort remainder", 64'(bus.remainder), 64'd0);
    check("abort div_by_zero", 64'(bus.div_by_zero), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_done |= bus.done;
      tick;
    end
    check("abort no done", 64'(seen_done), 64'd0);
    run_op(32'd12345, 32'd100);
    check("after abort quotient", 64'(rq), 64'd123);
    check("after abort remainder", 64'(rr), 64'd45);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 5000)) : $urandom;
      b = $urandom_range(0, 1) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      if (b == '0) b = 32'd1;
      run_op(a, b);
      check("rand latency", 64'(lat), 64'(W + 2));
      check("rand quotient", 64'(rq), 64'(a / b));
      check("rand remainder", 64'(rr), 64'(a % b));
      check("rand identity", 64'(rq) * 64'(b) + 64'(rr), 64'(a));
      check("rand remainder bound", 64'(rr < b), 64'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
